// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port plus CPU-facing
// instruction stream and redirect inputs.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, small prefetch FIFO,
// redirect flush. Define IFU_JUMP_PREDECODE_EN to follow J/JAL on fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);
  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_r, state_nxt;
  logic [31:0]       fetch_pc_r, fetch_pc_nxt, addr_nxt;
  logic [31:0]       target_s, pc_inc_s, seq_pc_s;
  logic              req_nxt, push_s, pop_s, bypass_s;
  logic [31:0]       fifo_instr_r [DEPTH];
  logic [31:0]       fifo_pc_r    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0]  count_r, count_nxt;
  logic [31:0]       head_instr_s, head_pc_s;

  assign target_s = {bus.redirect_target[31:2], 2'b00};
  assign pc_inc_s = bus.imem_addr + 32'd4;
  assign pop_s    = bus.instr_valid & bus.instr_ready & ~bus.redirect;

`ifdef IFU_JUMP_PREDECODE_EN
  logic jump_s;
  assign jump_s   = (bus.imem_rdata[31:26] == 6'b000010) || (bus.imem_rdata[31:26] == 6'b000011);
  assign seq_pc_s = jump_s ? {pc_inc_s[31:28], bus.imem_rdata[25:0], 2'b00} : pc_inc_s;
`else
  assign seq_pc_s = pc_inc_s;
`endif

  // Fetch FSM next state; a redirect during an unacked request keeps the bus held and drains
  always_comb begin
    state_nxt    = state_r;
    req_nxt      = bus.imem_req;
    addr_nxt     = bus.imem_addr;
    fetch_pc_nxt = fetch_pc_r;
    push_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.redirect) begin
          fetch_pc_nxt = target_s;
        end else if (count_r < DEPTH_C) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          addr_nxt  = fetch_pc_r;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
          if (bus.redirect) begin
            fetch_pc_nxt = target_s;
          end else begin
            push_s       = 1'b1;
            fetch_pc_nxt = seq_pc_s;
          end
        end else if (bus.redirect) begin
          state_nxt    = DRAIN;
          fetch_pc_nxt = target_s;
        end else begin
          state_nxt = REQ;
        end
      end
      DRAIN: begin
        if (bus.imem_ack) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end else begin
          state_nxt = DRAIN;
        end
        if (bus.redirect) begin
          fetch_pc_nxt = target_s;
        end else begin
          fetch_pc_nxt = fetch_pc_r;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // Fetch FSM state, fetch PC and registered memory request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      fetch_pc_r    <= RESET_PC;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= RESET_PC;
    end else begin
      state_r       <= state_nxt;
      fetch_pc_r    <= fetch_pc_nxt;
      bus.imem_req  <= req_nxt;
      bus.imem_addr <= addr_nxt;
    end
  end

  // FIFO bookkeeping; a word pushed into an empty (or emptying) FIFO bypasses to the head
  always_comb begin
    if (bus.redirect) begin
      count_nxt  = {CNT_W{1'b0}};
      rd_ptr_nxt = {PTR_W{1'b0}};
      wr_ptr_nxt = {PTR_W{1'b0}};
    end else begin
      count_nxt  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      rd_ptr_nxt = rd_ptr_r + PTR_W'(pop_s);
      wr_ptr_nxt = wr_ptr_r + PTR_W'(push_s);
    end
    bypass_s = push_s && (rd_ptr_nxt == wr_ptr_r);
    if (bypass_s) begin
      head_instr_s = bus.imem_rdata;
      head_pc_s    = bus.imem_addr;
    end else begin
      head_instr_s = fifo_instr_r[rd_ptr_nxt];
      head_pc_s    = fifo_pc_r[rd_ptr_nxt];
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_instr_r[i] <= 32'h0000_0000;
        fifo_pc_r[i]    <= 32'h0000_0000;
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_instr_r[wr_ptr_r] <= bus.imem_rdata;
        fifo_pc_r[wr_ptr_r]    <= bus.imem_addr;
      end
      rd_ptr_r <= rd_ptr_nxt;
      wr_ptr_r <= wr_ptr_nxt;
      count_r  <= count_nxt;
    end
  end

  // Registered view of the FIFO head; instr/instr_pc hold when the FIFO empties
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.instr       <= 32'h0000_0000;
      bus.instr_pc    <= 32'h0000_0000;
      bus.instr_valid <= 1'b0;
    end else begin
      bus.instr_valid <= (count_nxt != {CNT_W{1'b0}});
      if (count_nxt != {CNT_W{1'b0}}) begin
        bus.instr    <= head_instr_s;
        bus.instr_pc <= head_pc_s;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a behavioural imem
// (zero-wait or manually acked). Predecode case runs when IFU_JUMP_PREDECODE_EN is defined.
module tb_instr_fetch_unit;
  logic clk;
  logic reset;
  logic zero_wait;
  logic ack_force;
  logic jmp_en;
  int   err_cnt;
  int   chk_cnt;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] w;
    w = {8'hA5, a[23:0]};
    if (jmp_en && (a == 32'h0000_0008)) w = {6'b000010, 26'd203};
    return w;
  endfunction

  assign bus.imem_ack   = zero_wait ? bus.imem_req : ack_force;
  assign bus.imem_rdata = memword(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    ack_force       = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // With ready=1, expect n consecutive words starting at pc start
  task automatic collect(input int n, input logic [31:0] start);
    logic [31:0] exp;
    int got;
    exp = start;
    got = 0;
    for (int c = 0; c < 40 && got < n; c++) begin
      if (bus.instr_valid) begin
        check_eq("seq_pc", bus.instr_pc, exp);
        check_eq("seq_instr", bus.instr, memword(exp));
        exp = exp + 32'd4;
        got++;
      end
      @(negedge clk);
    end
    check_eq("seq_count", 32'(got), 32'(n));
  endtask

  initial begin
    err_cnt             = 0;
    chk_cnt             = 0;
    reset               = 1'b1;
    zero_wait           = 1'b1;
    ack_force           = 1'b0;
    jmp_en              = 1'b0;
    bus.instr_ready     = 1'b1;
    bus.redirect        = 1'b0;
    bus.redirect_target = 32'h0000_0000;

    // Reset state, first-word latency, sequential stream
    @(negedge clk);
    check_eq("rst_req", 32'(bus.imem_req), 32'd0);
    check_eq("rst_addr", bus.imem_addr, 32'h0000_0000);
    check_eq("rst_instr", bus.instr, 32'h0000_0000);
    check_eq("rst_pc", bus.instr_pc, 32'h0000_0000);
    check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("lat1_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("lat1_req", 32'(bus.imem_req), 32'd1);
    @(negedge clk);
    check_eq("lat2_valid", 32'(bus.instr_valid), 32'd1);
    collect(4, 32'h0000_0000);

    // Backpressure: exactly two words buffered, then drain in order
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    check_eq("full_req", 32'(bus.imem_req), 32'd0);
    check_eq("full_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("full_pc", bus.instr_pc, 32'h0000_0000);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check_eq("drain1_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("drain1_pc", bus.instr_pc, 32'h0000_0004);
    check_eq("drain1_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    check_eq("drain2_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("drain2_addr", bus.imem_addr, 32'h0000_0008);
    @(negedge clk);
    check_eq("drain3_pc", bus.instr_pc, 32'h0000_0008);
    check_eq("drain3_instr", bus.instr, memword(32'h0000_0008));

    // Redirect with full FIFO flushes and refetches from target (low bits cleared)
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h0000_0043;
    bus.instr_ready     = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b0;
    check_eq("flush_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("flush_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    check_eq("flush_addr", bus.imem_addr, 32'h0000_0040);
    @(negedge clk);
    check_eq("flush_pc", bus.instr_pc, 32'h0000_0040);

    // Redirect while a slow request is outstanding: held, dropped, then target fetched
    zero_wait = 1'b0;
    do_reset();
    @(negedge clk);
    check_eq("slow_req", 32'(bus.imem_req), 32'd1);
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h0000_0100;
    @(negedge clk);
    bus.redirect = 1'b0;
    check_eq("hold1_req", 32'(bus.imem_req), 32'd1);
    check_eq("hold1_addr", bus.imem_addr, 32'h0000_0000);
    @(negedge clk);
    check_eq("hold2_addr", bus.imem_addr, 32'h0000_0000);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    check_eq("drop_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("drop_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    check_eq("tgt_req", 32'(bus.imem_req), 32'd1);
    check_eq("tgt_addr", bus.imem_addr, 32'h0000_0100);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    check_eq("tgt_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("tgt_pc", bus.instr_pc, 32'h0000_0100);
    check_eq("tgt_instr", bus.instr, memword(32'h0000_0100));

    // Address wrap from top of memory
    zero_wait = 1'b1;
    do_reset();
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFE;
    @(negedge clk);
    bus.redirect = 1'b0;
    check_eq("wrap_idle_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    check_eq("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check_eq("wrap_pc0", bus.instr_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    check_eq("wrap_addr1", bus.imem_addr, 32'h0000_0000);
    @(negedge clk);
    check_eq("wrap_pc1", bus.instr_pc, 32'h0000_0000);

    // Async reset mid-request with FIFO non-empty, late ack afterwards ignored
    zero_wait       = 1'b0;
    bus.instr_ready = 1'b0;
    do_reset();
    @(negedge clk);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    check_eq("mid_req", 32'(bus.imem_req), 32'd1);
    check_eq("mid_valid", 32'(bus.instr_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("async_req", 32'(bus.imem_req), 32'd0);
    check_eq("async_addr", bus.imem_addr, 32'h0000_0000);
    ack_force = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ack_force = 1'b0;
    check_eq("late_ack_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("restart_addr", bus.imem_addr, 32'h0000_0000);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    check_eq("restart_pc", bus.instr_pc, 32'h0000_0000);
    check_eq("restart_valid", 32'(bus.instr_valid), 32'd1);

`ifdef IFU_JUMP_PREDECODE_EN
    // J at 0x8 redirects fetch to 0x32C without a CPU redirect
    begin
      logic [31:0] jaddr;
      jaddr           = 32'h0000_0000;
      zero_wait       = 1'b1;
      bus.instr_ready = 1'b1;
      jmp_en          = 1'b1;
      do_reset();
      for (int c = 0; c < 30; c++) begin
        if (bus.imem_req && (bus.imem_addr > 32'h0000_0008)) begin
          jaddr = bus.imem_addr;
          break;
        end
        @(negedge clk);
      end
      check_eq("jump_addr", jaddr, 32'h0000_032C);
      jmp_en = 1'b0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
